// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit for the single-cycle LEGv8 CPU.
// Holds the PC, fetches one 32-bit word at a time over a req/ack handshake,
// presents it to the decoder/datapath with a valid flag, and advances the PC
// to PC+4 or to a CondAddr19 / BrAddr26 branch target once it is retired.
module instruction_fetch_unit #(
    parameter int                ADDR_W   = 64,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,

    // instruction memory handshake
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [31:0]       imem_rdata,

    // decoder / datapath side
    output logic [31:0]       instruction,
    output logic              instr_valid,
    input  logic              instr_ready,
    input  logic              BrTaken,
    input  logic              UncondBr,
    output logic [ADDR_W-1:0] pc
);

    typedef enum logic {
        FETCH = 1'b0,
        ISSUE = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [31:0]       instr_q, instr_d;

    // Set by every reset edge and cleared by the first edge without reset.
    // It keeps imem_req and instr_valid low for the cycle following a reset
    // edge while both outputs stay purely registered (no path from reset).
    logic              rst_hold_q;

    logic [ADDR_W-1:0] br26_off;
    logic [ADDR_W-1:0] br19_off;
    logic [ADDR_W-1:0] next_pc;

    // Word offsets of the two branch formats, sign-extended to the PC width
    // and scaled by 4 (two zero bits appended).
    assign br26_off = {{(ADDR_W-28){instr_q[25]}}, instr_q[25:0], 2'b00};
    assign br19_off = {{(ADDR_W-21){instr_q[23]}}, instr_q[23:5], 2'b00};

    // Next-PC selection; UncondBr only matters when BrTaken is set, so an
    // undefined UncondBr on a fall-through instruction cannot leak in.
    always_comb begin
        next_pc = pc_q + ADDR_W'(4);
        if (BrTaken) begin
            if (UncondBr) begin
                next_pc = pc_q + br26_off;
            end else begin
                next_pc = pc_q + br19_off;
            end
        end
    end

    // State, PC and instruction registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= FETCH;
            pc_q       <= RESET_PC;
            instr_q    <= 32'h0;
            rst_hold_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            rst_hold_q <= 1'b0;
        end
    end

    // Next-state logic and registered-state output decode.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        instr_d     = instr_q;
        imem_req    = 1'b0;
        instr_valid = 1'b0;

        case (state_q)
            FETCH: begin
                // No request is outstanding in the cycle after reset, so an
                // ack seen then belongs to nothing and is dropped.
                if (!rst_hold_q) begin
                    imem_req = 1'b1;
                    if (imem_ack) begin
                        instr_d = imem_rdata;
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                instr_valid = !rst_hold_q;
                if (instr_ready) begin
                    pc_d    = next_pc;
                    state_d = FETCH;
                end
            end
            default: begin
                state_d = FETCH;
            end
        endcase
    end

    assign imem_addr   = pc_q;
    assign pc          = pc_q;
    assign instruction = instr_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: a directed table of branch
// cases, hand-written reset/stall sequences and a randomized run checked
// against a behavioural next-PC model.
module tb_instruction_fetch_unit;

    logic        clk;
    logic        reset;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instruction;
    logic        instr_valid;
    logic        instr_ready;
    logic        BrTaken;
    logic        UncondBr;
    logic [63:0] pc;

    int checks = 0;
    int errors = 0;
    logic [63:0] model_pc;

    instruction_fetch_unit #(
        .ADDR_W   (64),
        .RESET_PC (64'h0)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .instruction (instruction),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .BrTaken     (BrTaken),
        .UncondBr    (UncondBr),
        .pc          (pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference next PC computed from the branch rules as plain integers.
    function automatic logic [63:0] ref_next(input logic [63:0] p, input logic [31:0] ins,
                                             input bit bt, input bit ub);
        longint off;
        if (!bt) return p + 64'd4;
        if (ub) begin
            off = longint'(ins[25:0]);
            if (off >= 64'sd33554432) off = off - 64'sd67108864;
        end else begin
            off = longint'(ins[23:5]);
            if (off >= 64'sd262144) off = off - 64'sd524288;
        end
        return p + 64'(off * 4);
    endfunction

    // One full instruction: called just after a posedge with the DUT in FETCH.
    // Returns just after the posedge that re-enters FETCH at the new PC.
    task automatic do_instr(input logic [31:0] ins, input bit bt, input bit ub,
                            input int ack_wait, input int ready_wait);
        logic [63:0] start_pc;
        start_pc = model_pc;
        for (int w = 0; w < ack_wait; w++) begin
            chk("fetch_wait_req", imem_req, 1'b1);
            chk("fetch_wait_addr", imem_addr, model_pc);
            chk("fetch_wait_valid", instr_valid, 1'b0);
            imem_ack   = 1'b0;
            imem_rdata = $urandom;
            step();
        end
        chk("fetch_req", imem_req, 1'b1);
        chk("fetch_addr", imem_addr, model_pc);
        chk("fetch_valid", instr_valid, 1'b0);
        imem_ack   = 1'b1;
        imem_rdata = ins;
        step();
        imem_ack   = 1'b0;
        imem_rdata = $urandom;
        for (int r = 0; r < ready_wait; r++) begin
            chk("issue_stall_valid", instr_valid, 1'b1);
            chk("issue_stall_req", imem_req, 1'b0);
            chk("issue_stall_instr", instruction, ins);
            chk("issue_stall_pc", pc, model_pc);
            instr_ready = 1'b0;
            BrTaken     = 1'($urandom_range(0, 1));
            UncondBr    = 1'($urandom_range(0, 1));
            imem_ack    = 1'($urandom_range(0, 1));
            step();
            imem_ack    = 1'b0;
        end
        chk("issue_valid", instr_valid, 1'b1);
        chk("issue_req", imem_req, 1'b0);
        chk("issue_instr", instruction, ins);
        chk("issue_pc", pc, model_pc);
        instr_ready = 1'b1;
        BrTaken     = bt;
        UncondBr    = ub;
        step();
        instr_ready = 1'b0;
        BrTaken     = 1'b0;
        UncondBr    = 1'b0;
        model_pc = ref_next(model_pc, ins, bt, ub);
        chk("next_req", imem_req, 1'b1);
        chk("next_addr", imem_addr, model_pc);
        chk("next_valid", instr_valid, 1'b0);
        $display("instr pc=%h ins=%h bt=%0d ub=%0d ackw=%0d rdyw=%0d -> next=%h dut=%h",
                 start_pc, ins, bt, ub, ack_wait, ready_wait, model_pc, imem_addr);
    endtask

    // Move the PC to target using an unconditional B from the current PC.
    task automatic goto_pc(input logic [63:0] target);
        logic [63:0] diff;
        logic [31:0] ins;
        if (model_pc != target) begin
            diff = target - model_pc;
            ins  = 32'h1400_0000 | {6'b0, diff[27:2]};
            do_instr(ins, 1'b1, 1'b1, 0, 0);
        end
    endtask

    typedef struct {
        string       name;
        logic [63:0] start_pc;
        logic [31:0] ins;
        bit          bt;
        bit          ub;
        logic [63:0] exp_next;
    } vec_t;

    vec_t vecs[6];

    initial begin
        vecs[0] = '{"b_fwd",      64'h0,                   32'h1400_0003, 1'b1, 1'b1, 64'hC};
        vecs[1] = '{"b_back",     64'h40,                  32'h17FF_FFFE, 1'b1, 1'b1, 64'h38};
        vecs[2] = '{"cbz_taken",  64'h100,                 32'hB4FF_FFC0, 1'b1, 1'b0, 64'hF8};
        vecs[3] = '{"cbz_fall",   64'h100,                 32'hB4FF_FFC0, 1'b0, 1'b1, 64'h104};
        vecs[4] = '{"wrap",       64'hFFFF_FFFF_FFFF_FFFC, 32'h8B00_0000, 1'b0, 1'b0, 64'h0};
        vecs[5] = '{"b_self",     64'h200,                 32'h1400_0000, 1'b1, 1'b1, 64'h200};

        reset       = 1'b1;
        imem_ack    = 1'b0;
        imem_rdata  = 32'h0;
        instr_ready = 1'b0;
        BrTaken     = 1'b0;
        UncondBr    = 1'b0;
        model_pc    = 64'h0;

        // Reset state; a late ack during reset must be ignored.
        step();
        imem_ack   = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        step();
        chk("rst_pc", pc, 64'h0);
        chk("rst_instr", instruction, 32'h0);
        chk("rst_req", imem_req, 1'b0);
        chk("rst_valid", instr_valid, 1'b0);
        imem_ack = 1'b0;
        reset    = 1'b0;
        chk("rst_drop_req", imem_req, 1'b0);
        step();
        chk("req_after_rst", imem_req, 1'b1);

        // Zero-wait sequential fetch at 0, 4, 8.
        for (int i = 0; i < 3; i++) do_instr(32'h8B00_0000, 1'b0, 1'b0, 0, 0);

        // Directed branch table.
        foreach (vecs[i]) begin
            goto_pc(vecs[i].start_pc);
            do_instr(vecs[i].ins, vecs[i].bt, vecs[i].ub, 0, 0);
            chk(vecs[i].name, imem_addr, vecs[i].exp_next);
        end

        // Memory stall of 3 cycles plus datapath stall of 2 cycles.
        do_instr(32'h8B00_0000, 1'b0, 1'b0, 3, 2);

        // Reset while waiting on ack at 0x20, with an ack arriving at the reset edge.
        goto_pc(64'h20);
        step();
        chk("wait_addr_20", imem_addr, 64'h20);
        chk("wait_req_20", imem_req, 1'b1);
        reset      = 1'b1;
        imem_ack   = 1'b1;
        imem_rdata = 32'hCAFE_F00D;
        step();
        chk("midfetch_rst_pc", pc, 64'h0);
        chk("midfetch_rst_req", imem_req, 1'b0);
        chk("midfetch_rst_instr", instruction, 32'h0);
        reset    = 1'b0;
        imem_ack = 1'b0;
        step();
        model_pc = 64'h0;
        chk("midfetch_refetch_req", imem_req, 1'b1);
        chk("midfetch_refetch_addr", imem_addr, 64'h0);

        // Reset while in ISSUE overrides a retire with a taken branch.
        imem_ack   = 1'b1;
        imem_rdata = 32'h1400_0010;
        step();
        imem_ack = 1'b0;
        chk("issue_before_rst", instr_valid, 1'b1);
        reset       = 1'b1;
        instr_ready = 1'b1;
        BrTaken     = 1'b1;
        UncondBr    = 1'b1;
        step();
        chk("midissue_rst_pc", pc, 64'h0);
        chk("midissue_rst_valid", instr_valid, 1'b0);
        chk("midissue_rst_instr", instruction, 32'h0);
        reset       = 1'b0;
        instr_ready = 1'b0;
        BrTaken     = 1'b0;
        UncondBr    = 1'b0;
        step();
        chk("midissue_refetch_addr", imem_addr, 64'h0);

        // Randomized instructions, branches and stalls against the model.
        for (int n = 0; n < 60; n++) begin
            do_instr($urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     $urandom_range(0, 3), $urandom_range(0, 2));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
- Producer end of the instruction/branch interface of the single-cycle LEGv8 CPU.
- Holds the PC and fetches 32-bit instructions from instruction memory over a req/ack handshake.
- Presents each instruction, with a valid flag, to the control-signal decoder and datapath.
- Consumes the decoder's BrTaken/UncondBr to compute the next PC: PC+4, a CondAddr19 branch, or a BrAddr26 branch.

Parameters:
RESET_PC, 64'h0, PC value loaded on reset.
ADDR_W, 64, width of PC and memory address.

Ports:
clk  in  1  system clock; all state updates on the rising edge.
reset  in  1  synchronous, active-high reset.
imem_req  out  1  fetch request to instruction memory.
imem_addr  out  ADDR_W  fetch address; equals pc.
imem_ack  in  1  memory response valid; imem_rdata is valid in the same cycle.
imem_rdata  in  32  fetched instruction word.
instruction  out  32  registered instruction presented to the decoder and datapath.
instr_valid  out  1  instruction holds an unretired instruction.
instr_ready  in  1  datapath retires the current instruction this cycle.
BrTaken  in  1  from the decoder; branch taken for the current instruction.
UncondBr  in  1  from the decoder; 1 selects BrAddr26, 0 selects CondAddr19.
pc  out  ADDR_W  address of the current or pending instruction.

Behaviour:
- Reset is synchronous and active-high. On a clock edge with reset=1:
  - pc <= RESET_PC; state <= FETCH; instruction <= 32'h0.
  - instr_valid = 0 and imem_req = 0 for the reset cycle.
  - Reset overrides every other input, including mid-WAIT or mid-ISSUE.
- FSM has two states, FETCH and ISSUE.
- FETCH:
  - imem_req = 1, imem_addr = pc, instr_valid = 0.
  - imem_ack=0: stay in FETCH; req stays high and addr stays stable. There is no timeout.
  - imem_ack=1: instruction <= imem_rdata, go to ISSUE.
- ISSUE:
  - imem_req = 0, instr_valid = 1, instruction is held stable.
  - instr_ready=0: stay in ISSUE; pc and instruction are unchanged. BrTaken/UncondBr are ignored.
  - instr_ready=1: pc <= next_pc, go to FETCH.
- imem_ack is ignored outside FETCH. imem_rdata is ignored unless imem_ack=1 in FETCH.
- next_pc, evaluated only in ISSUE with instr_ready=1:
  - BrTaken=0: pc + 4.
  - BrTaken=1, UncondBr=1: pc + (sext64(instruction[25:0]) << 2).
  - BrTaken=1, UncondBr=0: pc + (sext64(instruction[23:5]) << 2).
  - X on UncondBr is tolerated when BrTaken=0: the result must not depend on UncondBr.
- Arithmetic: all adds are unsigned modulo 2^ADDR_W. Wrap-around is silent (e.g. pc=64'hFFFF_FFFF_FFFF_FFFC + 4 -> 0). Offsets are two's complement; negative branches must decrement pc.
- Latency:
  - Zero-wait memory (ack in the first FETCH cycle): 2 cycles per instruction when instr_ready is held high.
  - Each wait cycle on ack adds one cycle.
  - Each cycle instr_ready is held low adds one cycle.
- Outputs are decoded from the registered state and pc only; there are no combinational paths to imem_req or instr_valid. BrTaken/UncondBr may be combinational from instruction, so no loop exists.
- Branch to own address (offset 0) is legal: the same address is refetched.

Test Plan:
- Reset, then zero-wait memory returning 32'h8B000000 at 0, 4, 8 with instr_ready=1 and BrTaken=0:
  - imem_req rises the cycle after reset drops.
  - imem_addr sequence is 0, 4, 8, one new address every 2 cycles.
  - instr_valid pulses for 1 cycle per fetch.
- B at pc=0x0, instruction=32'h14000003, BrTaken=1, UncondBr=1 -> next imem_addr = 0xC.
- B backwards at pc=0x40, instruction=32'h17FFFFFE (imm26=-2), BrTaken=1, UncondBr=1 -> next imem_addr = 0x38.
- CBZ at pc=0x100, instruction[23:5]=19'h7FFFE (-2), UncondBr=0:
  - BrTaken=1 -> next imem_addr = 0xF8.
  - Same instruction with BrTaken=0 -> 0x104.
- Memory stall and datapath stall:
  - imem_ack delayed 3 cycles -> imem_req and imem_addr hold for 3 cycles, instr_valid stays 0.
  - instr_ready low for 2 cycles in ISSUE -> pc and instruction are unchanged, instr_valid stays 1.
- Boundary and reset cases:
  - pc=64'hFFFF_FFFF_FFFF_FFFC, BrTaken=0 -> next pc = 0 (wrap).
  - reset asserted while in FETCH waiting on ack at pc=0x20 -> next cycle pc=RESET_PC, imem_req=0.
  - A late ack during reset is ignored.
